sop_frame_accumulator: RTL
==========================

Name: sop_frame_accumulator

Overview:
Downstream consumer of the sum-of-products top stage. Takes the 8-bit SUM_OUT stream one sample per qualified cycle and accumulates fixed-length frames. For each frame it presents the frame sum and the frame peak to a downstream reader over a valid/ready handshake. The SOP stage cannot stall, so a frame that completes while the previous result is still unread is dropped and flagged.

Parameters:
IN_WIDTH, 8, width of incoming SOP sample (matches SOP OUT_WIDTH)
FRAME_LEN, 8, samples per frame; power of two, 2..16
CNT_WIDTH, 3, log2(FRAME_LEN)
ACC_WIDTH, 11, IN_WIDTH+CNT_WIDTH; frame sum width, never overflows

Ports:
clk  input  1  single system clock, rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  enable accumulation; sampled every cycle
in_valid  input  1  in_data holds a valid SOP sample this cycle
in_data  input  IN_WIDTH  SOP sample (unsigned)
out_ready  input  1  downstream accepts result this cycle
clr_ovr  input  1  synchronous clear of sticky overrun
out_valid  output  1  result registers hold an unread frame
out_sum  output  ACC_WIDTH  sum of the FRAME_LEN samples of the frame
out_max  output  IN_WIDTH  largest sample in the frame
overrun  output  1  sticky: at least one completed frame dropped
busy  output  1  FSM in ACCUM with count != 0 (partial frame held)

Behaviour:
- Reset (rst=0, async): state=IDLE, acc=0, cnt=0, peak=0, out_valid=0, out_sum=0, out_max=0, overrun=0, busy=0.
- Reset deasserts synchronously to clk externally; no internal synchroniser.
- States: IDLE, ACCUM.
- IDLE -> ACCUM when en=1. Samples are ignored in the transition cycle.
- ACCUM -> IDLE when en=0: partial frame discarded, acc/cnt/peak zeroed. out_valid, out_sum, out_max and overrun are untouched.
- In ACCUM with in_valid=1:
  - acc += zero-extended in_data.
  - peak = max(peak, in_data).
  - cnt += 1.
- in_valid=0 cycles are gaps: no state change.
- Frame completion is the in_valid cycle with cnt==FRAME_LEN-1. On that edge:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: out_sum <= acc+in_data, out_max <= max(peak,in_data), out_valid <= 1.
  - Otherwise: result dropped, overrun <= 1, old outputs held.
  - In every case acc, cnt and peak return to 0, and the FSM stays in ACCUM.
- Latency: out_valid rises on the edge that consumes the last sample, i.e. visible 1 cycle after the last in_valid.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both 1 at a rising edge.
  - out_valid drops next cycle unless a new frame completes in that same cycle (back-to-back load, no bubble).
  - out_sum and out_max are stable while out_valid=1 and not yet accepted.
- out_ready while out_valid=0 has no effect.
- clr_ovr=1 clears overrun next edge. If a drop occurs in the same cycle, set wins (overrun stays 1).
- en=0 in the same cycle as frame completion: the sample is not accumulated and no frame is produced.
- Arithmetic: unsigned only. ACC_WIDTH guarantees no wrap: max 255*8=2040 < 2048.

Decomposition:
- Shared package sop_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_ACCUM=1'b1
  - SOP_OUT_WIDTH=8
  - default FRAME_LEN and derived CNT_WIDTH/ACC_WIDTH
- One natural sub-module, sop_frame_counter: cnt register with clear, increment and terminal-count flag. Accumulate/peak/output registers and FSM stay in the parent.

Test Plan:
1. rst=0 for 3 cycles mid-stream -> all outputs 0 immediately (before the next clk edge); after release with en=0, nothing changes for 10 cycles.
2. FRAME_LEN=8, en=1, in_valid every cycle, data 10,20,30,40,50,60,70,80, out_ready=1 -> out_valid one cycle after sample 8, out_sum=360, out_max=80, held exactly 1 cycle.
3. Same data with in_valid gaps (1 on, 2 off), out_ready=0 -> out_sum=360 held stable; out_valid drops the cycle after out_ready pulses high.
4. Two full frames of 255, out_ready=0 throughout -> first frame out_sum=2040, out_max=255; second frame dropped, overrun=1; clr_ovr pulse -> overrun=0, out_sum still 2040.
5. Frames back-to-back with out_ready pulsed exactly on the second completion cycle -> no overrun, out_valid stays 1, out_sum updates to the second frame.
6. en drops after 5 samples of 7, then rises again with 8 samples of 1 -> out_sum=8, out_max=1, no result from the partial frame.

Source files
------------

// File: rtl/sop_pkg.sv
// sop_pkg: shared widths, default frame geometry and FSM encoding for the SOP stage
package sop_pkg;
  localparam int SOP_OUT_WIDTH = 8;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_CNT_WIDTH = $clog2(DEF_FRAME_LEN);
  localparam int DEF_ACC_WIDTH = SOP_OUT_WIDTH + DEF_CNT_WIDTH;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_t;
endpackage

// File: rtl/sop_frame_counter.sv
// sop_frame_counter: sample-in-frame counter with clear, increment and terminal-count flag
module sop_frame_counter #(
  parameter int FRAME_LEN = 8,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 tc
);
  assign tc = cnt == CNT_WIDTH'(FRAME_LEN - 1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else cnt <= clr ? '0 : inc ? cnt + CNT_WIDTH'(1) : cnt;
endmodule

// File: rtl/sop_frame_accumulator.sv
// sop_frame_accumulator: sums fixed-length SOP frames and hands sum/peak downstream over valid/ready,
// dropping (and flagging) a frame that completes while the previous result is still unread.
module sop_frame_accumulator
  import sop_pkg::*;
#(
  parameter int IN_WIDTH  = SOP_OUT_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int CNT_WIDTH = $clog2(FRAME_LEN),
  parameter int ACC_WIDTH = IN_WIDTH + CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 out_ready,
  input  logic                 clr_ovr,
  output logic                 out_valid,
  output logic [ACC_WIDTH-1:0] out_sum,
  output logic [IN_WIDTH-1:0]  out_max,
  output logic                 overrun,
  output logic                 busy
);
  state_t state, nxt;
  logic [ACC_WIDTH-1:0] acc, sum_n;
  logic [IN_WIDTH-1:0] peak, max_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic tc, run, take, done, load;
  assign run   = state == ST_ACCUM && en;
  assign take  = run && in_valid;
  assign done  = take && tc;
  assign load  = done && (!out_valid || out_ready);
  assign sum_n = acc + ACC_WIDTH'(in_data);
  assign max_n = in_data > peak ? in_data : peak;
  assign busy  = state == ST_ACCUM && cnt != '0;
  sop_frame_counter #(.FRAME_LEN(FRAME_LEN), .CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .clk(clk), .rst(rst), .clr(!run || done), .inc(take), .cnt(cnt), .tc(tc)
  );
  always_comb nxt = en ? ST_ACCUM : ST_IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= nxt;
  // leaving ACCUM or closing a frame both restart the partial sum and peak
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc  <= '0;
      peak <= '0;
    end else begin
      acc  <= (!run || done) ? '0 : take ? sum_n : acc;
      peak <= (!run || done) ? '0 : take ? max_n : peak;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_max   <= '0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= load || (out_valid && !out_ready);
      out_sum   <= load ? sum_n : out_sum;
      out_max   <= load ? max_n : out_max;
      overrun   <= (done && !load) || (overrun && !clr_ovr);
    end
endmodule
